// File: rtl/tetris_pkg.sv
// Shared Tetris datapath definitions: board geometry defaults, row type and
// the line-clear sequencer state encoding.
package tetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;

  typedef logic [BOARD_W-1:0] row_t;

  // Fixed encodings keep the state bus stable for legacy debug tooling.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CHK_RD  = 3'd1;
  localparam logic [2:0] ST_CHK     = 3'd2;
  localparam logic [2:0] ST_SH_RD   = 3'd3;
  localparam logic [2:0] ST_SH_WR   = 3'd4;
  localparam logic [2:0] ST_CLR_TOP = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    CHK_RD  = ST_CHK_RD,
    CHK     = ST_CHK,
    SH_RD   = ST_SH_RD,
    SH_WR   = ST_SH_WR,
    CLR_TOP = ST_CLR_TOP,
    DONE    = ST_DONE
  } rc_state_t;

endpackage

// File: rtl/board_row_clear_if.sv
// Control handshake plus board RAM port between game logic, the row-clear
// sequencer and the single-port board RAM.
interface board_row_clear_if #(
  parameter int BOARD_W = 10,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 5
);
  logic               start;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   lines_cleared;
  logic               ram_wen;
  logic [ADDR_W-1:0]  ram_addr;
  logic [BOARD_W-1:0] ram_din;
  logic [BOARD_W-1:0] ram_dout;

  modport master (
    output start, ram_dout,
    input  busy, done, lines_cleared, ram_wen, ram_addr, ram_din
  );

  modport slave (
    input  start, ram_dout,
    output busy, done, lines_cleared, ram_wen, ram_addr, ram_din
  );
endinterface

// File: rtl/board_row_clear.sv
// Line-clear sequencer: scans the board bottom to top, deletes full rows by
// shifting everything above down one row, and reports how many were removed.
module board_row_clear #(
  parameter int BOARD_W = tetris_pkg::BOARD_W,
  parameter int BOARD_H = tetris_pkg::BOARD_H,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 5
) (
  input logic              clk,
  input logic              reset,
  board_row_clear_if.slave bus
);
  import tetris_pkg::*;

  localparam logic [BOARD_W-1:0] FULL_ROW = {BOARD_W{1'b1}};
  localparam logic [ADDR_W-1:0]  LAST_ROW = ADDR_W'(BOARD_H - 1);

  rc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] r_q, r_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  lines_q, lines_d;

  // Next-state and datapath-register update for the scan/shift sequence.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CHK_RD;
          r_d     = LAST_ROW;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      CHK_RD: state_d = CHK;
      CHK: begin
        if (bus.ram_dout == FULL_ROW) begin
          cnt_d   = cnt_q + CNT_W'(1);
          k_d     = r_q;
          state_d = (r_q != {ADDR_W{1'b0}}) ? SH_RD : CLR_TOP;
        end else if (r_q != {ADDR_W{1'b0}}) begin
          r_d     = r_q - ADDR_W'(1);
          state_d = CHK_RD;
        end else begin
          // Result is published on entry so it is valid alongside done.
          lines_d = cnt_q;
          state_d = DONE;
        end
      end
      SH_RD: state_d = SH_WR;
      SH_WR: begin
        if (k_q > ADDR_W'(1)) begin
          k_d     = k_q - ADDR_W'(1);
          state_d = SH_RD;
        end else begin
          state_d = CLR_TOP;
        end
      end
      // r is left alone so the row that just dropped into it is re-checked.
      CLR_TOP: state_d = CHK_RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= {ADDR_W{1'b0}};
      k_q     <= {ADDR_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      lines_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
    end
  end

  // Outputs decoded from registered state; the write data forwards the
  // RAM's own registered read port during a shift write.
  always_comb begin
    bus.busy          = (state_q != IDLE);
    bus.done          = (state_q == DONE);
    bus.lines_cleared = lines_q;
    bus.ram_wen       = 1'b0;
    bus.ram_addr      = {ADDR_W{1'b0}};
    bus.ram_din       = {BOARD_W{1'b0}};
    case (state_q)
      CHK_RD: bus.ram_addr = r_q;
      SH_RD:  bus.ram_addr = k_q - ADDR_W'(1);
      SH_WR: begin
        bus.ram_wen  = 1'b1;
        bus.ram_addr = k_q;
        bus.ram_din  = bus.ram_dout;
      end
      CLR_TOP: begin
        bus.ram_wen  = 1'b1;
        bus.ram_addr = {ADDR_W{1'b0}};
        bus.ram_din  = {BOARD_W{1'b0}};
      end
      default: begin
        bus.ram_wen  = 1'b0;
        bus.ram_addr = {ADDR_W{1'b0}};
        bus.ram_din  = {BOARD_W{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_board_row_clear.sv
// Directed bench for board_row_clear paired with a behavioural board RAM.
module tb_board_row_clear;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  board_row_clear_if #(.BOARD_W(10), .ADDR_W(5), .CNT_W(5)) bus ();

  board_row_clear #(.BOARD_W(10), .BOARD_H(20), .ADDR_W(5), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [9:0] mem [0:19];
  logic [9:0] img [0:19];
  logic       ld = 1'b0;
  logic [9:0] dout_q = 10'd0;
  int         wr_cnt = 0;
  logic [4:0] wr_addr = 5'd0;
  logic [9:0] wr_data = 10'd0;
  int         n_tests = 0;
  int         n_fail = 0;

  assign bus.ram_dout = dout_q;

  // Board RAM: registered read, output held during writes, bulk preload.
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 20; i++) mem[i] <= img[i];
    end else if (bus.ram_wen) begin
      if (bus.ram_addr < 5'd20) mem[bus.ram_addr] <= bus.ram_din;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.ram_addr;
      wr_data <= bus.ram_din;
    end else begin
      dout_q <= (bus.ram_addr < 5'd20) ? mem[bus.ram_addr] : 10'd0;
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 20; i++) img[i] = 10'd0;
  endtask

  task automatic do_load();
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
  endtask

  // Pulses start, returns the cycle number in which done was seen.
  task automatic run_pass(input int poke_cyc, output int cyc);
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.start = (poke_cyc != 0) && (cyc == poke_cyc || cyc == poke_cyc + 1);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ram_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b wen=%b expected 0 0 0", bus.busy, bus.done, bus.ram_wen);
    end
    n_tests++;
    if (bus.lines_cleared !== 5'd0 || bus.ram_addr !== 5'd0 || bus.ram_din !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_data: lines=%0d addr=%0d din=%h expected 0 0 0", bus.lines_cleared, bus.ram_addr, bus.ram_din);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_ignored: busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_empty(input string tag);
    int cyc, w0, bad;
    clear_img();
    do_load();
    w0 = wr_cnt;
    run_pass(0, cyc);
    n_tests++;
    if (cyc !== 41) begin n_fail++; $display("FAIL %s_cycles: got %0d expected 41", tag, cyc); end
    n_tests++;
    if (bus.lines_cleared !== 5'd0) begin n_fail++; $display("FAIL %s_lines: got %0d expected 0", tag, bus.lines_cleared); end
    // start coincident with done must be ignored
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s_start_at_done: busy=%b expected 0", tag, bus.busy); end
    n_tests++;
    if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL %s_writes: got %0d expected 0", tag, wr_cnt - w0); end
    bad = 0;
    for (int i = 0; i < 20; i++) if (mem[i] !== 10'd0) bad++;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL %s_ram: %0d rows changed expected 0", tag, bad); end
  endtask

  task automatic test_single(input int poke, input string tag);
    int cyc, bad;
    clear_img();
    img[19] = 10'h3FF;
    img[18] = 10'h001;
    do_load();
    run_pass(poke, cyc);
    n_tests++;
    if (cyc !== 82) begin n_fail++; $display("FAIL %s_cycles: got %0d expected 82", tag, cyc); end
    n_tests++;
    if (bus.lines_cleared !== 5'd1) begin n_fail++; $display("FAIL %s_lines: got %0d expected 1", tag, bus.lines_cleared); end
    @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 19; i++) if (mem[i] !== 10'd0) bad++;
    n_tests++;
    if (mem[19] !== 10'h001 || bad !== 0) begin
      n_fail++;
      $display("FAIL %s_ram: row19=%h nonzero_upper=%0d expected 001 0", tag, mem[19], bad);
    end
  endtask

  task automatic test_nonadjacent();
    int cyc, bad;
    clear_img();
    img[19] = 10'h3FF;
    img[18] = 10'h155;
    img[17] = 10'h3FF;
    img[16] = 10'h2AA;
    do_load();
    run_pass(0, cyc);
    n_tests++;
    if (cyc !== 121) begin n_fail++; $display("FAIL nonadj_cycles: got %0d expected 121", cyc); end
    n_tests++;
    if (bus.lines_cleared !== 5'd2) begin n_fail++; $display("FAIL nonadj_lines: got %0d expected 2", bus.lines_cleared); end
    @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 18; i++) if (mem[i] !== 10'd0) bad++;
    n_tests++;
    if (mem[19] !== 10'h155 || mem[18] !== 10'h2AA || bad !== 0) begin
      n_fail++;
      $display("FAIL nonadj_ram: row19=%h row18=%h nonzero_upper=%0d expected 155 2aa 0", mem[19], mem[18], bad);
    end
  endtask

  task automatic test_top_row();
    int cyc, w0;
    clear_img();
    img[0]  = 10'h3FF;
    img[19] = 10'h200;
    do_load();
    w0 = wr_cnt;
    run_pass(0, cyc);
    n_tests++;
    if (cyc !== 44) begin n_fail++; $display("FAIL top_cycles: got %0d expected 44", cyc); end
    n_tests++;
    if (wr_cnt - w0 !== 1 || wr_addr !== 5'd0 || wr_data !== 10'd0) begin
      n_fail++;
      $display("FAIL top_write: count=%0d addr=%0d data=%h expected 1 0 000", wr_cnt - w0, wr_addr, wr_data);
    end
    n_tests++;
    if (bus.lines_cleared !== 5'd1 || mem[19] !== 10'h200 || mem[0] !== 10'd0) begin
      n_fail++;
      $display("FAIL top_result: lines=%0d row19=%h row0=%h expected 1 200 000", bus.lines_cleared, mem[19], mem[0]);
    end
  endtask

  task automatic test_full_board();
    int cyc, bad;
    for (int i = 0; i < 20; i++) img[i] = 10'h3FF;
    do_load();
    run_pass(0, cyc);
    n_tests++;
    if (cyc !== 861) begin n_fail++; $display("FAIL full_cycles: got %0d expected 861", cyc); end
    n_tests++;
    if (bus.lines_cleared !== 5'd20 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_done: lines=%0d busy=%b expected 20 1", bus.lines_cleared, bus.busy);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL full_busy_fall: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) if (mem[i] !== 10'd0) bad++;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL full_ram: %0d nonzero rows expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    int guard, w0;
    clear_img();
    img[19] = 10'h3FF;
    do_load();
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    guard = 0;
    while (!(bus.ram_wen === 1'b1 && bus.ram_addr === 5'd19) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    n_tests++;
    if (guard >= 200) begin n_fail++; $display("FAIL midrst_reach_shwr: timeout after %0d cycles", guard); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.ram_wen !== 1'b0 || bus.lines_cleared !== 5'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: busy=%b wen=%b lines=%0d expected 0 0 0", bus.busy, bus.ram_wen, bus.lines_cleared);
    end
    reset = 1'b0;
    w0 = wr_cnt;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (wr_cnt - w0 !== 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_quiet: writes=%0d busy=%b expected 0 0", wr_cnt - w0, bus.busy);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    reset = 1'b0;
    clear_img();
    test_reset();
    test_empty("empty");
    test_single(0, "single");
    test_nonadjacent();
    test_top_row();
    test_full_board();
    test_single(10, "start_busy");
    test_reset_mid();
    test_empty("fresh");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
